// File: rtl/mem_types_pkg.sv
// Shared types and sizing for the cacheline <-> banked-memory adapter.
package mem_types_pkg;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int ADDR_W      = 32;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_W       = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        RD_RESP  = 3'd3,
        WR_BURST = 3'd4
    } cl_adapter_state_t;

    typedef logic [BEATS-1:0][BEAT_W-1:0] line_beats_t;

    // Bursts always start on a line boundary, so the byte offset is dropped.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_itf.sv
// 256-bit cacheline request/response interface between cache side and adapter.
interface cacheline_itf;
    import mem_types_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
    logic              ready;
    logic [ADDR_W-1:0] raddr;
    logic [LINE_W-1:0] rdata;
    logic              rvalid;

    modport slave  (input addr, read, write, wdata, output ready, raddr, rdata, rvalid);
    modport master (output addr, read, write, wdata, input ready, raddr, rdata, rvalid);

endinterface

// File: rtl/cacheline_adapter_chk.sv
// Protocol checks on the request side of the cacheline adapter.
module cacheline_adapter_chk (
    input logic clk,
    input logic rst,
    input logic read,
    input logic write
);

    // A master must never ask for a read and a write in the same cycle.
    property p_no_dual_req;
        @(posedge clk) disable iff (rst) !(read && write);
    endproperty

    a_no_dual_req: assert property (p_no_dual_req)
        else $error("cacheline_adapter: read and write asserted together");

endmodule

// File: rtl/cacheline_adapter.sv
// Responder end of the cacheline interface: turns each line read/write into a
// four-beat burst on the 64-bit memory port, one transaction at a time.
module cacheline_adapter
    import mem_types_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    cacheline_itf.slave       dfp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    cl_adapter_state_t state_r;
    cl_adapter_state_t state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    line_beats_t       line_r;
    logic [ADDR_W-1:0] resp_addr_r;
    logic [LINE_W-1:0] resp_line_r;
    line_beats_t       assembled_s;
    logic              accept_s;
    logic              beat_hit_s;

    assign accept_s   = (state_r == IDLE) && (dfp.read || dfp.write);
    // Only beats tagged with our own line address count; stray traffic is ignored.
    assign beat_hit_s = (state_r == RD_WAIT) && bmem_rvalid && (bmem_raddr == addr_r);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; read wins if both requests are raised.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (dfp.read) begin
                    state_next_s = RD_REQ;
                end else if (dfp.write) begin
                    state_next_s = WR_BURST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_next_s = RD_WAIT;
                end else begin
                    state_next_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (beat_hit_s && (cnt_r == LAST_BEAT)) begin
                    state_next_s = RD_RESP;
                end else begin
                    state_next_s = RD_WAIT;
                end
            end
            RD_RESP: state_next_s = IDLE;
            WR_BURST: begin
                if (bmem_ready && (cnt_r == LAST_BEAT)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WR_BURST;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Line as it will look once the current read beat is folded in.
    always_comb begin
        assembled_s        = line_r;
        assembled_s[cnt_r] = bmem_rdata;
    end

    // Beat assembly / serialisation and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= '0;
            addr_r      <= '0;
            line_r      <= '0;
            resp_addr_r <= '0;
            resp_line_r <= '0;
        end else if (accept_s) begin
            cnt_r  <= '0;
            addr_r <= line_align(dfp.addr);
            line_r <= dfp.wdata;
        end else if (beat_hit_s) begin
            cnt_r  <= cnt_r + CNT_W'(1);
            line_r <= assembled_s;
            if (cnt_r == LAST_BEAT) begin
                resp_addr_r <= addr_r;
                resp_line_r <= assembled_s;
            end else begin
                resp_addr_r <= resp_addr_r;
            end
        end else if ((state_r == WR_BURST) && bmem_ready) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Memory-side outputs decoded from the registered state.
    always_comb begin
        bmem_read  = (state_r == RD_REQ);
        bmem_write = (state_r == WR_BURST);
        if ((state_r == RD_REQ) || (state_r == WR_BURST)) begin
            bmem_addr = addr_r;
        end else begin
            bmem_addr = '0;
        end
        if (state_r == WR_BURST) begin
            bmem_wdata = line_r[cnt_r];
        end else begin
            bmem_wdata = '0;
        end
    end

    assign dfp.ready  = (state_r == IDLE);
    assign dfp.rvalid = (state_r == RD_RESP);
    assign dfp.raddr  = resp_addr_r;
    assign dfp.rdata  = resp_line_r;

    cacheline_adapter_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .read  (dfp.read),
        .write (dfp.write)
    );

endmodule
